base_fifo: RTL and testbench

BASE_FIFO -- requirements
Module: base_fifo

---
 rtl/base_pkg.sv | 9 +
 rtl/base_fifo_ptr.sv | 30 +++
 rtl/base_fifo.sv | 110 +++++++++++
 tb/tb_base_fifo.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/base_pkg.sv
// Shared sizing helper for the base FIFO family.
package base_pkg;

    // Width of a pointer (occ=0) or of an occupancy counter (occ=1) for a given depth.
    function automatic int unsigned fifo_w(input int unsigned d, input bit occ);
        return occ ? $clog2(d + 1) : $clog2(d);
    endfunction

endpackage

// File: rtl/base_fifo_ptr.sv
// Wrapping FIFO pointer; depth must be a power of two so the natural overflow wraps.
module base_fifo_ptr
    import base_pkg::*;
#(
    parameter int unsigned depth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inc,
    output logic [fifo_w(depth, 1'b0)-1:0] ptr
);

    localparam int unsigned PW = fifo_w(depth, 1'b0);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) ptr_d = ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/base_fifo.sv
// Synchronous valid/ready FIFO with registered flags and occupancy count.
// Optional upstream protocol checker enabled by BASE_FIFO_PROTOCOL_CHECK_EN.
module base_fifo
    import base_pkg::*;
#(
    parameter int unsigned width = 1,
    parameter int unsigned depth = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_v,
    output logic                             i_r,
    input  logic [0:width-1]                 i_d,
    output logic                             o_v,
    input  logic                             o_r,
    output logic [0:width-1]                 o_d,
    output logic [0:fifo_w(depth, 1'b1)-1]   o_cnt,
    output logic                             o_err
);

    localparam int unsigned PW = fifo_w(depth, 1'b0);
    localparam int unsigned CW = fifo_w(depth, 1'b1);

    logic [0:width-1] mem_q [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             push, pop;

    assign push = i_v && ready_q;
    assign pop  = valid_q && o_r;

    base_fifo_ptr #(.depth(depth)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    base_fifo_ptr #(.depth(depth)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // Occupancy and flags are computed from the next count so they stay registered.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        ready_d = (cnt_d != CW'(depth));
        valid_d = (cnt_d != CW'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr] <= i_d;
    end

    assign i_r   = ready_q;
    assign o_v   = valid_q;
    assign o_d   = mem_q[rd_ptr];
    assign o_cnt = cnt_q;

`ifdef BASE_FIFO_PROTOCOL_CHECK_EN
    logic             stall_q;
    logic [0:width-1] held_q;
    logic             err_q, err_d;
    logic             viol;

    // A stalled offer must stay valid with unchanged payload until accepted.
    assign viol  = stall_q && (!i_v || (i_d != held_q));
    assign err_d = err_q || viol;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 1'b0;
            held_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= i_v && !ready_q;
            held_q  <= i_d;
            err_q   <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_base_fifo.sv
// Directed bench for base_fifo at width=8, depth=4.
module tb_base_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_v;
    logic       i_r;
    logic [0:7] i_d;
    logic       o_v;
    logic       o_r;
    logic [0:7] o_d;
    logic [0:2] o_cnt;
    logic       o_err;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BASE_FIFO_PROTOCOL_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    base_fifo #(.width(8), .depth(4)) dut (
        .clk   (clk),
        .reset (reset),
        .i_v   (i_v),
        .i_r   (i_r),
        .i_d   (i_d),
        .o_v   (o_v),
        .o_r   (o_r),
        .o_d   (o_d),
        .o_cnt (o_cnt),
        .o_err (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

        reset = 1'b1; i_v = 1'b0; o_r = 1'b0; i_d = 8'h00;
        #1;
        check("rst_o_v", 32'(o_v), 32'd0);
        check("rst_i_r", 32'(i_r), 32'd1);
        check("rst_cnt", 32'(o_cnt), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        tick(); tick();
        reset = 1'b0;

        // Fill to full with the consumer stalled.
        for (int k = 0; k < 4; k++) begin
            i_v = 1'b1; i_d = vals[k];
            tick();
            check("fill_cnt", 32'(o_cnt), 32'(k + 1));
            check("fill_o_v", 32'(o_v), 32'd1);
            check("fill_o_d", 32'(o_d), 32'h11);
        end
        check("full_i_r", 32'(i_r), 32'd0);
        i_d = 8'h55;
        tick();
        check("full_cnt_hold", 32'(o_cnt), 32'd4);
        check("full_o_d_hold", 32'(o_d), 32'h11);
        check("full_i_r_hold", 32'(i_r), 32'd0);

        // Drain with 0x55 still offered; it may only enter after the first pop.
        o_r = 1'b1;
        check("drain0_o_d", 32'(o_d), 32'h11);
        tick();
        check("drain1_cnt", 32'(o_cnt), 32'd3);
        check("drain1_o_d", 32'(o_d), 32'h22);
        check("drain1_i_r", 32'(i_r), 32'd1);
        tick();
        check("drain2_cnt", 32'(o_cnt), 32'd3);
        check("drain2_o_d", 32'(o_d), 32'h33);
        i_v = 1'b0;
        tick();
        check("drain3_cnt", 32'(o_cnt), 32'd2);
        check("drain3_o_d", 32'(o_d), 32'h44);
        tick();
        check("drain4_cnt", 32'(o_cnt), 32'd1);
        check("drain4_o_d", 32'(o_d), 32'h55);
        tick();
        check("drain5_cnt", 32'(o_cnt), 32'd0);
        check("drain5_o_v", 32'(o_v), 32'd0);

        // Continuous stream: one entry in flight, pointers wrap repeatedly.
        for (int k = 0; k < 16; k++) begin
            i_v = 1'b1; i_d = 8'(k);
            if (k > 0) begin
                check("stream_o_d", 32'(o_d), 32'(k - 1));
                check("stream_cnt", 32'(o_cnt), 32'd1);
                check("stream_o_v", 32'(o_v), 32'd1);
            end
            tick();
        end
        i_v = 1'b0;
        check("stream_last_o_d", 32'(o_d), 32'h0F);
        tick();
        check("stream_end_cnt", 32'(o_cnt), 32'd0);
        o_r = 1'b0;

        // Reset asserted mid-cycle at occupancy 3.
        for (int k = 0; k < 3; k++) begin
            i_v = 1'b1; i_d = 8'(k + 1);
            tick();
        end
        check("pre_rst_cnt", 32'(o_cnt), 32'd3);
        #3;
        reset = 1'b1;
        i_v = 1'b0;
        #1;
        check("mid_rst_o_v", 32'(o_v), 32'd0);
        check("mid_rst_cnt", 32'(o_cnt), 32'd0);
        check("mid_rst_i_r", 32'(i_r), 32'd1);
        tick();
        reset = 1'b0;
        i_v = 1'b1; i_d = 8'hA5;
        tick();
        i_v = 1'b0;
        check("post_rst_o_v", 32'(o_v), 32'd1);
        check("post_rst_o_d", 32'(o_d), 32'hA5);
        check("post_rst_cnt", 32'(o_cnt), 32'd1);
        o_r = 1'b1;
        tick();
        o_r = 1'b0;
        check("post_rst_pop", 32'(o_cnt), 32'd0);

        // Payload change while stalled at full.
        for (int k = 0; k < 4; k++) begin
            i_v = 1'b1; i_d = 8'(k + 1);
            tick();
        end
        i_d = 8'h5A;
        tick();
        check("stall_err0", 32'(o_err), 32'd0);
        i_d = 8'hA5;
        tick();
        check("viol_err", 32'(o_err), 32'(ERR_EXP));
        i_v = 1'b0;
        tick();
        check("viol_err_sticky", 32'(o_err), 32'(ERR_EXP));
        check("viol_no_store", 32'(o_cnt), 32'd4);
        check("viol_o_d", 32'(o_d), 32'h01);
        tick();
        check("viol_err_sticky2", 32'(o_err), 32'(ERR_EXP));
        reset = 1'b1;
        #1;
        check("err_cleared", 32'(o_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
